// File: rtl/countdown_digits_pkg.sv
// Shared types and constants for the four-digit BCD countdown timer.
package countdown_digits_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  function automatic logic [3:0] sat_bcd(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/countdown_digits_if.sv
// Control/preset inputs and BCD/status outputs of the countdown timer.
interface countdown_digits_if;
  logic       load;
  logic [3:0] preset_ones, preset_tens, preset_hundreds, preset_thousands;
  logic       start, pause;
  logic [3:0] ones, tens, hundreds, thousands;
  logic       running, done, expired;

  modport master (
    output load, preset_ones, preset_tens, preset_hundreds, preset_thousands, start, pause,
    input  ones, tens, hundreds, thousands, running, done, expired
  );
  modport slave (
    input  load, preset_ones, preset_tens, preset_hundreds, preset_thousands, start, pause,
    output ones, tens, hundreds, thousands, running, done, expired
  );
endinterface

// File: rtl/countdown_digits_bcd_digit_dn.sv
// One BCD digit register with decrement and borrow chaining.
module bcd_digit_dn
  import countdown_digits_pkg::*;
(
  input  logic       clk_10Hz,
  input  logic       reset,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec_en,
  input  logic       i_borrow_in,
  output logic [3:0] o_digit,
  output logic       o_borrow_out
);
  logic [3:0] r_digit;

  always_ff @(posedge clk_10Hz or posedge reset) begin
    if (reset)                        r_digit <= BCD_ZERO;
    else if (i_load)                  r_digit <= i_load_val;
    else if (i_dec_en && i_borrow_in) r_digit <= (r_digit == BCD_ZERO) ? BCD_MAX : r_digit - 4'd1;
  end

  assign o_digit      = r_digit;
  assign o_borrow_out = (r_digit == BCD_ZERO) && i_borrow_in;
endmodule

// File: rtl/countdown_digits.sv
// Four-digit BCD countdown timer: FSM, stored preset, zero detect and expiry pulse.
module countdown_digits
  import countdown_digits_pkg::*;
#(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input logic               clk_10Hz,
  input logic               reset,
  countdown_digits_if.slave bus
);
  state_e          r_state, w_state_nxt;
  logic [3:0][3:0] w_digits, w_sat, w_ld_val, r_preset;
  logic [4:0]      w_borrow;
  logic            w_zero, w_one, w_dig_load, w_dec, w_expired_nxt, r_expired;

  assign w_sat = {sat_bcd(bus.preset_thousands), sat_bcd(bus.preset_hundreds),
                  sat_bcd(bus.preset_tens),      sat_bcd(bus.preset_ones)};
  assign w_ld_val = bus.load ? w_sat : r_preset;

  // The borrow chain is seeded with 1, so it ripples out the top only when every digit is 0.
  assign w_borrow[0] = 1'b1;
  assign w_zero      = w_borrow[4];
  assign w_one       = (w_digits == 16'h0001);

  for (genvar g = 0; g < 4; g++) begin : g_dig
    bcd_digit_dn u_dig (
      .clk_10Hz     (clk_10Hz),
      .reset        (reset),
      .i_load       (w_dig_load),
      .i_load_val   (w_ld_val[g]),
      .i_dec_en     (w_dec),
      .i_borrow_in  (w_borrow[g]),
      .o_digit      (w_digits[g]),
      .o_borrow_out (w_borrow[g+1])
    );
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_dig_load    = 1'b0;
    w_dec         = 1'b0;
    w_expired_nxt = 1'b0;
    if (bus.load) begin
      w_state_nxt = IDLE;
      w_dig_load  = 1'b1;
    end else begin
      case (r_state)
        IDLE:   if (bus.start && !bus.pause && !w_zero) w_state_nxt = RUN;
        RUN: begin
          if (bus.pause) w_state_nxt = PAUSED;
          else if (!w_zero) begin
            w_dec = 1'b1;
            if (w_one) begin
              w_state_nxt   = DONE;
              w_expired_nxt = 1'b1;
            end
          end
        end
        PAUSED: if (bus.start && !bus.pause) w_state_nxt = RUN;
        DONE: begin
          if (AUTO_RELOAD) begin
            if (r_preset == 16'h0000) w_state_nxt = IDLE;
            else begin
              w_dig_load  = 1'b1;
              w_state_nxt = bus.pause ? PAUSED : RUN;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_10Hz or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_preset  <= '0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_expired <= w_expired_nxt;
      if (bus.load) r_preset <= w_sat;
    end
  end

  assign bus.ones      = w_digits[0];
  assign bus.tens      = w_digits[1];
  assign bus.hundreds  = w_digits[2];
  assign bus.thousands = w_digits[3];
  assign bus.running   = (r_state == RUN);
  assign bus.done      = (r_state == DONE);
  assign bus.expired   = r_expired;
endmodule

// File: tb/tb_countdown_digits.sv
// Directed vector bench for countdown_digits, one instance per AUTO_RELOAD setting.
module tb_countdown_digits;
  logic clk_10Hz = 1'b0;
  logic reset    = 1'b1;
  always #5 clk_10Hz = ~clk_10Hz;

  countdown_digits_if if0 ();
  countdown_digits_if if1 ();

  countdown_digits #(.AUTO_RELOAD(1'b0)) dut0 (.clk_10Hz(clk_10Hz), .reset(reset), .bus(if0.slave));
  countdown_digits #(.AUTO_RELOAD(1'b1)) dut1 (.clk_10Hz(clk_10Hz), .reset(reset), .bus(if1.slave));

  typedef struct {
    bit          sel;
    bit          ld;
    logic [15:0] pre;
    bit          st;
    bit          pa;
    logic [15:0] cnt;
    bit          run;
    bit          dn;
    bit          ex;
    string       name;
  } vec_t;

  vec_t q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(bit sel, bit ld, logic [15:0] pre, bit st, bit pa,
                              logic [15:0] cnt, bit run, bit dn, bit ex, string name);
    vec_t v;
    v.sel = sel; v.ld = ld; v.pre = pre; v.st = st; v.pa = pa;
    v.cnt = cnt; v.run = run; v.dn = dn; v.ex = ex; v.name = name;
    q.push_back(v);
  endfunction

  function automatic logic [18:0] observe(bit sel);
    if (sel) return {if1.thousands, if1.hundreds, if1.tens, if1.ones, if1.running, if1.done, if1.expired};
    return {if0.thousands, if0.hundreds, if0.tens, if0.ones, if0.running, if0.done, if0.expired};
  endfunction

  task automatic check(bit sel, logic [18:0] exp, string name);
    logic [18:0] got;
    got = observe(sel);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got cnt=%h run=%b done=%b exp=%b, want cnt=%h run=%b done=%b exp=%b",
               name, got[18:3], got[2], got[1], got[0], exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic idle_inputs();
    if0.load = 0; if0.start = 0; if0.pause = 0;
    {if0.preset_thousands, if0.preset_hundreds, if0.preset_tens, if0.preset_ones} = 16'h0;
    if1.load = 0; if1.start = 0; if1.pause = 0;
    {if1.preset_thousands, if1.preset_hundreds, if1.preset_tens, if1.preset_ones} = 16'h0;
  endtask

  task automatic run_vecs();
    foreach (q[i]) begin
      idle_inputs();
      if (q[i].sel) begin
        if1.load = q[i].ld; if1.start = q[i].st; if1.pause = q[i].pa;
        {if1.preset_thousands, if1.preset_hundreds, if1.preset_tens, if1.preset_ones} = q[i].pre;
      end else begin
        if0.load = q[i].ld; if0.start = q[i].st; if0.pause = q[i].pa;
        {if0.preset_thousands, if0.preset_hundreds, if0.preset_tens, if0.preset_ones} = q[i].pre;
      end
      @(posedge clk_10Hz); #1;
      check(q[i].sel, {q[i].cnt, q[i].run, q[i].dn, q[i].ex}, q[i].name);
    end
    q.delete();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    #1;
    check(0, 19'h0, "reset0");
    check(1, 19'h0, "reset1");
    @(negedge clk_10Hz); reset = 0;

    // Count into 0421, then reset asynchronously between edges.
    add(0, 1, 16'h0422, 0, 0, 16'h0422, 0, 0, 0, "ld0422");
    add(0, 0, 16'h0,    1, 0, 16'h0422, 1, 0, 0, "start0422");
    add(0, 0, 16'h0,    0, 0, 16'h0421, 1, 0, 0, "dec0421");
    run_vecs();
    #2 reset = 1;
    #1 check(0, 19'h0, "async_reset");
    @(negedge clk_10Hz); reset = 0;

    add(0, 0, 16'h0,    1, 0, 16'h0000, 0, 0, 0, "post_reset_start0");
    add(0, 1, 16'h0015, 0, 0, 16'h0015, 0, 0, 0, "ld0015");
    add(0, 1, 16'h1000, 0, 0, 16'h1000, 0, 0, 0, "ld1000");
    add(0, 0, 16'h0,    1, 0, 16'h1000, 1, 0, 0, "start1000");
    add(0, 0, 16'h0,    0, 0, 16'h0999, 1, 0, 0, "borrow0999");
    add(0, 0, 16'h0,    0, 0, 16'h0998, 1, 0, 0, "dec0998");
    add(0, 1, 16'h0100, 0, 0, 16'h0100, 0, 0, 0, "ld0100");
    add(0, 0, 16'h0,    1, 0, 16'h0100, 1, 0, 0, "start0100");
    add(0, 0, 16'h0,    0, 0, 16'h0099, 1, 0, 0, "borrow0099");
    add(0, 1, 16'h0003, 0, 0, 16'h0003, 0, 0, 0, "ld0003");
    add(0, 0, 16'h0,    1, 0, 16'h0003, 1, 0, 0, "start0003");
    add(0, 0, 16'h0,    0, 0, 16'h0002, 1, 0, 0, "dec0002");
    add(0, 0, 16'h0,    0, 0, 16'h0001, 1, 0, 0, "dec0001");
    add(0, 0, 16'h0,    0, 0, 16'h0000, 0, 1, 1, "expire");
    add(0, 0, 16'h0,    0, 0, 16'h0000, 0, 1, 0, "expire_one_cycle");
    run_vecs();

    // DONE holds 0000 and ignores start/pause for 20 edges.
    for (int i = 0; i < 20; i++) begin
      if0.start = i[0]; if0.pause = i[1];
      @(posedge clk_10Hz); #1;
      check(0, {16'h0000, 1'b0, 1'b1, 1'b0}, "done_hold");
    end
    idle_inputs();

    add(0, 1, 16'h0052, 0, 0, 16'h0052, 0, 0, 0, "ld0052");
    add(0, 0, 16'h0,    1, 0, 16'h0052, 1, 0, 0, "start0052");
    add(0, 0, 16'h0,    0, 0, 16'h0051, 1, 0, 0, "dec0051");
    add(0, 0, 16'h0,    0, 0, 16'h0050, 1, 0, 0, "dec0050");
    add(0, 0, 16'h0,    0, 1, 16'h0050, 0, 0, 0, "pause_hold");
    add(0, 0, 16'h0,    1, 1, 16'h0050, 0, 0, 0, "start_pause_hold");
    add(0, 0, 16'h0,    1, 0, 16'h0050, 1, 0, 0, "resume");
    add(0, 0, 16'h0,    1, 0, 16'h0049, 1, 0, 0, "resume_dec0049");
    add(0, 1, 16'hAB3F, 0, 0, 16'h9939, 0, 0, 0, "saturate9939");
    add(0, 1, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, "ld0000");
    add(0, 0, 16'h0,    1, 0, 16'h0000, 0, 0, 0, "start_zero_ignored");
    add(0, 0, 16'h0,    1, 0, 16'h0000, 0, 0, 0, "start_zero_no_expire");
    add(0, 1, 16'h0007, 1, 1, 16'h0007, 0, 0, 0, "load_beats_start_pause");
    add(0, 0, 16'h0,    1, 1, 16'h0007, 0, 0, 0, "idle_pause_beats_start");
    add(0, 0, 16'h0,    1, 0, 16'h0007, 1, 0, 0, "start0007");
    add(0, 0, 16'h0,    0, 0, 16'h0006, 1, 0, 0, "dec0006");

    // Auto-reload instance.
    add(1, 1, 16'h0002, 0, 0, 16'h0002, 0, 0, 0, "ar_ld0002");
    add(1, 0, 16'h0,    1, 0, 16'h0002, 1, 0, 0, "ar_start");
    add(1, 0, 16'h0,    0, 0, 16'h0001, 1, 0, 0, "ar_dec0001");
    add(1, 0, 16'h0,    0, 0, 16'h0000, 0, 1, 1, "ar_expire1");
    add(1, 0, 16'h0,    0, 0, 16'h0002, 1, 0, 0, "ar_reload");
    add(1, 0, 16'h0,    0, 0, 16'h0001, 1, 0, 0, "ar_dec0001b");
    add(1, 0, 16'h0,    0, 0, 16'h0000, 0, 1, 1, "ar_expire2");
    add(1, 1, 16'h0005, 0, 0, 16'h0005, 0, 0, 0, "ar_load_beats_reload");
    add(1, 0, 16'h0,    0, 0, 16'h0005, 0, 0, 0, "ar_idle_hold");
    add(1, 1, 16'h0001, 0, 0, 16'h0001, 0, 0, 0, "ar_ld0001");
    add(1, 0, 16'h0,    1, 0, 16'h0001, 1, 0, 0, "ar_start0001");
    add(1, 0, 16'h0,    0, 0, 16'h0000, 0, 1, 1, "ar_expire3");
    add(1, 0, 16'h0,    0, 1, 16'h0001, 0, 0, 0, "ar_reload_paused");
    add(1, 0, 16'h0,    1, 0, 16'h0001, 1, 0, 0, "ar_resume");
    add(1, 0, 16'h0,    0, 0, 16'h0000, 0, 1, 1, "ar_expire4");
    run_vecs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
